sincos_arb: RTL and testbench
=============================

# sincos_arb

Round-robin arbiter and tag tracker that shares one pipelined `sincos` core between NREQ requesters. Each requester offers a 10-bit angle with a valid/ready handshake. The block issues at most one angle per cycle to the core and tracks each issue's requester ID through the core's fixed latency. It returns the 5-bit sine/cosine pair tagged with that ID. It sits between the requesting datapaths and the single `sincos` instance.

## Interface
- NREQ, 4: number of requesters (2..8).
- AW, 10: angle width; matches core input `a`.
- OW, 5: result width; matches core outputs `s`, `c`.
- LAT, 4: core latency. An angle on `core_a` in cycle k produces `core_s`/`core_c` valid in cycle k+LAT.
- IDW, $clog2(NREQ): ID width.

Ports:
- clk  in  1  rising-edge clock.
- areset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_angle  in  NREQ*AW  packed angles; requester i occupies bits [i*AW +: AW].
- req_ready  out  NREQ  one-hot grant; combinational from req_valid, hold and pointer.
- hold  in  1  when high, no grants are issued.
- core_a  out  AW  registered angle driven to the core.
- core_s  in  OW  core sine output.
- core_c  in  OW  core cosine output.
- rsp_valid  out  1  registered response strobe.
- rsp_id  out  IDW  requester index of the response.
- rsp_s  out  OW  registered sine result.
- rsp_c  out  OW  registered cosine result.
- busy  out  1  high while any issue is in flight.

## Operation
- Arbitration: round-robin pointer `last`, reset value NREQ-1.
  - Grant the first i with req_valid[i]=1, searching cyclically from last+1.
  - At most one req_ready bit is high; all are low when hold=1 or no request is valid.
- Transfer occurs on req_valid[i] & req_ready[i]. On transfer:
  - core_a ← angle of requester i.
  - last ← i.
  - Tag {1, i} enters the tag pipeline.
- With no transfer: core_a holds its value, and `last` is unchanged.
- The tag pipeline is LAT+1 stages deep. Stage 0 is aligned with core_a; stage LAT is aligned with core_s/core_c.
- When the final stage is valid, in the same edge:
  - rsp_valid ← 1.
  - rsp_id, rsp_s, rsp_c ← tag id, core_s, core_c.
  Otherwise rsp_valid ← 0, and rsp_id/rsp_s/rsp_c hold their values.
- Responses have no backpressure; consumers must accept every rsp_valid pulse.
- busy = OR of all tag-pipeline valid bits.
- Angle arithmetic: none. Angles pass through unmodified; wrap-around of the 10-bit phase is the core's concern.

## Timing
- Reset (areset=0, asynchronous):
  - core_a=0, rsp_valid=0, rsp_id=0, rsp_s=0, rsp_c=0.
  - All tag valids=0, busy=0, last=NREQ-1.
  - req_ready=0 while reset is asserted.
- Latency: a handshake in cycle t gives rsp_valid=1 in cycle t+LAT+2, which is 6 cycles at default.
- Throughput: one transfer per cycle sustained. Back-to-back issues give back-to-back responses in issue order.
- Fairness: with all NREQ requesting continuously, each requester is granted exactly once per NREQ cycles.
- Simultaneous events:
  - hold rising mid-stream stops new grants only; in-flight tags still complete.
  - A requester deasserting valid without ready loses nothing.
- Reset mid-operation: all in-flight tags are discarded and no response is produced for them. The first grant after reset release goes to requester 0.
- A pointer wrap from NREQ-1 to 0 is a plain modulo step.

## Structure
- Package `sincos_pkg` holds:
  - Localparams AW=10, OW=5 and the default LAT.
  - A typedef for the tag struct {valid, id}.
  - A function that returns the next round-robin grant index.
- Sub-module `sincos_tagpipe` is a parameterised LAT+1 shift register of tags with async active-low clear. It outputs the final-stage tag and the OR of all valids.
- The arbiter, core_a register and response register live in the top level.

## Test plan
- Reset: hold areset=0 with all req_valid=1 → all outputs 0, req_ready=0. Release areset → first grant is requester 0, and busy rises one cycle later.
- Single request: requester 2 sends angle 0x100 at cycle t → core_a=0x100 at t+1. rsp_valid pulses for exactly one cycle at t+6 with rsp_id=2 and rsp_s/rsp_c equal to core_s/core_c of cycle t+5.
- Full contention: all four requesters valid for 8 cycles → grant order 0,1,2,3,0,1,2,3, and 8 responses arrive in the same ID order at consecutive cycles.
- Hold: assert hold for 3 cycles during contention → req_ready=0 throughout. In-flight responses still arrive, and the grant resumes at the next index after `last`.
- Reset mid-flight: issue 3 requests, then pulse areset low 2 cycles later → no rsp_valid ever appears for them, and busy=0 immediately.
- Sparse requesters: only requesters 1 and 3 valid → grants alternate 1,3,1,3, and no cycle is idle.

Source files
------------

// File: rtl/sincos_pkg.sv
// ---------------------------------------------------------------------------
// sincos_pkg
// Shared definitions for the sincos arbiter slice:
//   - default angle/result widths and core latency
//   - tag_t   : {valid, id} travelling alongside an angle through the core
//   - grant_t : result of a round-robin search {found, idx}
//   - rr_next : first valid requester searching cyclically from last+1
// ---------------------------------------------------------------------------
package sincos_pkg;

   localparam int AW       = 10;  // angle width into the sincos core
   localparam int OW       = 5;   // sine/cosine result width
   localparam int LAT      = 4;   // default core latency in cycles
   localparam int MAX_NREQ = 8;   // largest supported requester count
   localparam int TAG_IDW  = 3;   // id width wide enough for MAX_NREQ

   typedef struct packed {
      logic               valid;
      logic [TAG_IDW-1:0] id;
   } tag_t;

   typedef struct packed {
      logic               found;
      logic [TAG_IDW-1:0] idx;
   } grant_t;

   // Requesters above nreq must be presented as zero in valid.
   // The search starts at last+1 and wraps modulo nreq.
   function automatic grant_t rr_next(input logic [MAX_NREQ-1:0] valid,
                                      input logic [TAG_IDW-1:0]  last,
                                      input int                  nreq);
      grant_t     g;
      logic [3:0] idx;
      g = '0;
      for (int k = 1; k <= MAX_NREQ; k++) begin
         idx = {1'b0, last} + 4'(k);
         if (idx >= 4'(nreq)) idx = idx - 4'(nreq);
         if ((k <= nreq) && !g.found && valid[idx[2:0]]) begin
            g.found = 1'b1;
            g.idx   = idx[2:0];
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/sincos_tagpipe.sv
// ---------------------------------------------------------------------------
// sincos_tagpipe
// Shift register of tags that runs in lock-step with the sincos core.
// Stage 0 lines up with the registered core angle, stage DEPTH-1 with the
// core's sine/cosine outputs.
// Ports:
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low clear of every stage
//   tag_i   in   tag entering stage 0
//   tag_o   out  tag held in the final stage
//   busy_o  out  OR of every stage's valid bit
// ---------------------------------------------------------------------------
module sincos_tagpipe
   import sincos_pkg::*;
#(
   parameter int DEPTH = LAT + 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  tag_t tag_i,
   output tag_t tag_o,
   output logic busy_o
);

   tag_t stage_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) busy_o = busy_o | stage_q[i].valid;
   end

   assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sincos_arb.sv
// ---------------------------------------------------------------------------
// sincos_arb
// Round-robin arbiter sharing one pipelined sincos core between NREQ
// requesters, with a tag pipeline that returns each result labelled with
// the requester that issued it.
//
// Handshake: a requester presents req_valid[i] with its angle and may drop
// or change it at any time; the block raises at most one req_ready bit,
// combinationally, and a transfer happens on a clock edge where
// req_valid[i] & req_ready[i] are both high. Responses carry no ready:
// every rsp_valid pulse must be taken in the cycle it appears.
//
// Ports:
//   clk        in   rising-edge clock
//   areset     in   asynchronous active-low reset
//   req_valid  in   [NREQ]     per-requester valid
//   req_angle  in   [NREQ*AW]  angle of requester i at [i*AW +: AW]
//   req_ready  out  [NREQ]     one-hot grant
//   hold       in   blocks all grants while high
//   core_a     out  [AW]       registered angle to the core
//   core_s     in   [OW]       core sine, LAT cycles after core_a
//   core_c     in   [OW]       core cosine, LAT cycles after core_a
//   rsp_valid  out  registered response strobe
//   rsp_id     out  [IDW]      requester index of the response
//   rsp_s      out  [OW]       registered sine
//   rsp_c      out  [OW]       registered cosine
//   busy       out  any issue still in flight
// ---------------------------------------------------------------------------
module sincos_arb #(
   parameter  int NREQ = 4,
   parameter  int AW   = sincos_pkg::AW,
   parameter  int OW   = sincos_pkg::OW,
   parameter  int LAT  = sincos_pkg::LAT,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               areset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_angle,
   output logic [NREQ-1:0]    req_ready,
   input  logic               hold,
   output logic [AW-1:0]      core_a,
   input  logic [OW-1:0]      core_s,
   input  logic [OW-1:0]      core_c,
   output logic               rsp_valid,
   output logic [IDW-1:0]     rsp_id,
   output logic [OW-1:0]      rsp_s,
   output logic [OW-1:0]      rsp_c,
   output logic               busy
);

   import sincos_pkg::*;

   logic [IDW-1:0]      last_q,      last_d;
   logic [AW-1:0]       core_a_q,    core_a_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]      rsp_id_q,    rsp_id_d;
   logic [OW-1:0]       rsp_s_q,     rsp_s_d;
   logic [OW-1:0]       rsp_c_q,     rsp_c_d;

   logic [MAX_NREQ-1:0] valid_ext;
   logic [TAG_IDW-1:0]  last_ext;
   grant_t              grant;
   logic [IDW-1:0]      gidx;
   logic                xfer;
   tag_t                tag_in;
   tag_t                tag_fin;

   // Arbitration and next-state logic.
   always_comb begin
      valid_ext                 = '0;
      valid_ext[NREQ-1:0]       = req_valid;
      last_ext                  = '0;
      last_ext[IDW-1:0]         = last_q;
      grant                     = rr_next(valid_ext, last_ext, NREQ);
      gidx                      = grant.idx[IDW-1:0];

      // Grants are suppressed while reset is held so that nothing upstream
      // sees a ready that the flops cannot honour.
      req_ready = '0;
      if (areset && !hold && grant.found) req_ready[gidx] = 1'b1;
      xfer = |(req_valid & req_ready);

      last_d   = last_q;
      core_a_d = core_a_q;
      tag_in   = '0;
      if (xfer) begin
         last_d       = gidx;
         core_a_d     = req_angle[gidx*AW +: AW];
         tag_in.valid = 1'b1;
         tag_in.id    = grant.idx;
      end

      rsp_valid_d = tag_fin.valid;
      rsp_id_d    = rsp_id_q;
      rsp_s_d     = rsp_s_q;
      rsp_c_d     = rsp_c_q;
      if (tag_fin.valid) begin
         rsp_id_d = tag_fin.id[IDW-1:0];
         rsp_s_d  = core_s;
         rsp_c_d  = core_c;
      end
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         last_q      <= IDW'(NREQ - 1);
         core_a_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_s_q     <= '0;
         rsp_c_q     <= '0;
      end else begin
         last_q      <= last_d;
         core_a_q    <= core_a_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_s_q     <= rsp_s_d;
         rsp_c_q     <= rsp_c_d;
      end
   end

   // LAT+1 stages: stage 0 sits beside core_a, the last beside core_s/c.
   sincos_tagpipe #(
      .DEPTH (LAT + 1)
   ) u_tagpipe (
      .clk_i  (clk),
      .rst_ni (areset),
      .tag_i  (tag_in),
      .tag_o  (tag_fin),
      .busy_o (busy)
   );

   // Tag ids are sized for the largest arbiter; the spare high bits are
   // always zero here and are folded into an unused net.
   logic unused_tag_id;
   assign unused_tag_id = ^tag_fin.id;

   assign core_a    = core_a_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_s     = rsp_s_q;
   assign rsp_c     = rsp_c_q;

endmodule

// File: tb/tb_sincos_arb.sv
// ---------------------------------------------------------------------------
// tb_sincos_arb
// Drives sincos_arb with directed scenarios followed by random traffic. A
// small core model returns a known function of each angle LAT cycles later;
// a reference model of the arbiter keeps a queue of issued transactions
// with the cycle each response is due and checks every output on every
// falling edge.
// ---------------------------------------------------------------------------
module tb_sincos_arb;

   localparam int NREQ = 4;
   localparam int AW   = 10;
   localparam int OW   = 5;
   localparam int LAT  = 4;
   localparam int IDW  = 2;
   localparam int EW   = 32 + IDW + AW;   // {due cycle, id, angle}

   // ---------------- clock / reset ----------------
   logic               clk       = 1'b0;
   logic               areset    = 1'b1;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ*AW-1:0] req_angle = '0;
   logic               hold      = 1'b0;
   logic [NREQ-1:0]    req_ready;
   logic [AW-1:0]      core_a;
   logic [OW-1:0]      core_s;
   logic [OW-1:0]      core_c;
   logic               rsp_valid;
   logic [IDW-1:0]     rsp_id;
   logic [OW-1:0]      rsp_s;
   logic [OW-1:0]      rsp_c;
   logic               busy;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   sincos_arb dut (
      .clk       (clk),
      .areset    (areset),
      .req_valid (req_valid),
      .req_angle (req_angle),
      .req_ready (req_ready),
      .hold      (hold),
      .core_a    (core_a),
      .core_s    (core_s),
      .core_c    (core_c),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_s     (rsp_s),
      .rsp_c     (rsp_c),
      .busy      (busy)
   );

   // ---------------- core model ----------------
   function automatic logic [OW-1:0] f_sin(input logic [AW-1:0] a);
      return a[9:5] ^ 5'h15;
   endfunction

   function automatic logic [OW-1:0] f_cos(input logic [AW-1:0] a);
      return a[4:0] + a[9:5];
   endfunction

   logic [LAT-1:0][AW-1:0] a_hist = '0;
   always @(posedge clk) a_hist <= {a_hist[LAT-2:0], core_a};
   assign core_s = f_sin(a_hist[LAT-1]);
   assign core_c = f_cos(a_hist[LAT-1]);

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [EW-1:0] exp_q[$];
   int grant_log[$];
   int rsp_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int model_grant(input logic [NREQ-1:0] v, input int last);
      int vi;
      int idx;
      vi = int'(v);
      for (int k = 1; k <= NREQ; k++) begin
         idx = (last + k) % NREQ;
         if (((vi >> idx) & 1) != 0) return idx;
      end
      return -1;
   endfunction

   int             m_last = NREQ - 1;
   logic [AW-1:0]  m_core_a = '0;
   logic [IDW-1:0] m_id = '0;
   logic [OW-1:0]  m_s = '0;
   logic [OW-1:0]  m_c = '0;

   always @(negedge clk) begin
      logic [EW-1:0]   e;
      logic            e_rv;
      logic            e_busy;
      logic [NREQ-1:0] e_rdy;
      logic [AW-1:0]   ang;
      int              g;
      if (!areset) begin
         chk("rst_req_ready", 32'(req_ready), 0);
         chk("rst_core_a",    32'(core_a),    0);
         chk("rst_rsp_valid", 32'(rsp_valid), 0);
         chk("rst_rsp_id",    32'(rsp_id),    0);
         chk("rst_rsp_s",     32'(rsp_s),     0);
         chk("rst_rsp_c",     32'(rsp_c),     0);
         chk("rst_busy",      32'(busy),      0);
         exp_q.delete();
         m_last   = NREQ - 1;
         m_core_a = '0;
         m_id     = '0;
         m_s      = '0;
         m_c      = '0;
      end else begin
         chk("core_a", 32'(core_a), 32'(m_core_a));

         e_rv = 1'b0;
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (int'(e[EW-1 -: 32]) == cyc) begin
               void'(exp_q.pop_front());
               e_rv = 1'b1;
               m_id = e[AW +: IDW];
               m_s  = f_sin(e[AW-1:0]);
               m_c  = f_cos(e[AW-1:0]);
            end
         end
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
         chk("rsp_id",    32'(rsp_id),    32'(m_id));
         chk("rsp_s",     32'(rsp_s),     32'(m_s));
         chk("rsp_c",     32'(rsp_c),     32'(m_c));
         if (rsp_valid) rsp_log.push_back(int'(rsp_id));

         // An issue is in flight from the cycle after its handshake until
         // the cycle before its response appears.
         e_busy = 1'b0;
         foreach (exp_q[i])
            if (int'(exp_q[i][EW-1 -: 32]) - LAT - 1 <= cyc) e_busy = 1'b1;
         chk("busy", 32'(busy), 32'(e_busy));

         g     = hold ? -1 : model_grant(req_valid, m_last);
         e_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
         chk("req_ready", 32'(req_ready), 32'(e_rdy));
         if (g >= 0) begin
            ang = req_angle[g*AW +: AW];
            exp_q.push_back({32'(cyc + LAT + 2), IDW'(g), ang});
            grant_log.push_back(g);
            m_last   = g;
            m_core_a = ang;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_angles();
      for (int i = 0; i < NREQ; i++) req_angle[i*AW +: AW] = AW'($urandom);
   endtask

   task automatic drain(input int n);
      req_valid = '0;
      hold      = 1'b0;
      repeat (n) step();
   endtask

   task automatic chk_log(input string name, input int log_q[$], input int exp_a[8], input int n);
      chk({name, "_count"}, 32'(log_q.size()), 32'(n));
      for (int i = 0; i < n; i++)
         if (i < log_q.size()) chk(name, 32'(log_q[i]), 32'(exp_a[i]));
   endtask

   // ---------------- stimulus ----------------
   int order_full[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
   int order_sparse[8] = '{1, 3, 1, 3, 0, 0, 0, 0};

   initial begin
      #1;
      // Reset with every requester asking.
      areset    = 1'b0;
      req_valid = '1;
      rand_angles();
      repeat (3) step();
      chk("reset_ready_lit", 32'(req_ready), 0);
      chk("reset_busy_lit",  32'(busy),      0);
      areset = 1'b1;
      #1;
      chk("first_grant_lit", 32'(req_ready), 32'(4'b0001));
      step();
      chk("busy_rise_lit", 32'(busy), 1);
      drain(10);

      // Single request from requester 2.
      req_valid = 4'b0100;
      req_angle[2*AW +: AW] = 10'h100;
      #1;
      chk("single_ready_lit", 32'(req_ready), 32'(4'b0100));
      step();
      req_valid = '0;
      chk("single_core_a_lit", 32'(core_a), 32'h100);
      repeat (4) step();
      chk("single_early_lit", 32'(rsp_valid), 0);
      step();
      chk("single_rsp_valid_lit", 32'(rsp_valid), 1);
      chk("single_rsp_id_lit",    32'(rsp_id),    2);
      chk("single_rsp_s_lit",     32'(rsp_s),     32'h1d);
      chk("single_rsp_c_lit",     32'(rsp_c),     32'h08);
      step();
      chk("single_pulse_lit", 32'(rsp_valid), 0);
      drain(4);

      // Full contention straight out of reset.
      areset = 1'b0;
      repeat (2) step();
      grant_log.delete();
      rsp_log.delete();
      req_valid = '1;
      rand_angles();
      areset = 1'b1;
      repeat (8) begin
         step();
         rand_angles();
      end
      drain(10);
      chk_log("full_grants", grant_log, order_full, 8);
      chk_log("full_rsp_ids", rsp_log, order_full, 8);

      // Hold during contention: last grant is 1, so resume at 2.
      req_valid = '1;
      repeat (2) step();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_ready_lit", 32'(req_ready), 0);
         step();
      end
      hold = 1'b0;
      #1;
      chk("hold_resume_lit", 32'(req_ready), 32'(4'b0100));
      repeat (3) step();
      drain(10);

      // Reset while three issues are in flight.
      rsp_log.delete();
      req_valid = '1;
      repeat (3) step();
      req_valid = '0;
      repeat (2) step();
      areset = 1'b0;
      #1;
      chk("midrst_busy_lit", 32'(busy), 0);
      repeat (2) step();
      areset = 1'b1;
      repeat (10) step();
      chk("midrst_no_rsp_lit", 32'(rsp_log.size()), 0);

      // Only requesters 1 and 3, pointer at 3 after reset.
      grant_log.delete();
      req_valid = 4'b1010;
      repeat (4) step();
      drain(10);
      chk_log("sparse_grants", grant_log, order_sparse, 4);

      // Random traffic with occasional hold and reset.
      for (int n = 0; n < 600; n++) begin
         req_valid = (n % 100 < 20) ? '1 : NREQ'($urandom);
         hold      = ($urandom_range(0, 9) == 0);
         areset    = ($urandom_range(0, 79) != 0);
         rand_angles();
         step();
      end
      areset = 1'b1;
      drain(12);
      chk("drain_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
